alu_sequencer: RTL and testbench

Command-side controller that drives the datapath ALU's `selector`, `a` and `b` inputs and consumes its `y`/`zero` outputs. It accepts one command at a time over a valid/ready handshake and sequences the ALU over one or more cycles: single ops, iterated ops, and shift-add multiply. It returns the result over a valid/ready response channel. It sits between the datapath control logic and the combinational ALU instance.

---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the command channel, the response channel and
// the ALU drive/return wires between the sequencer and its neighbours.
//   cmd_*  : valid/ready command (op, sel, a, b, cnt)
//   rsp_*  : valid/ready response (data, zero, err)
//   alu_*  : selector/operands out to the combinational ALU, y/zero back
// slave  = sequencer side, master = control logic + ALU side.
interface alu_sequencer_if #(parameter int WIDTH = 32);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [3:0]       cmd_sel;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [7:0]       cmd_cnt;
   logic [3:0]       alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;
   logic             rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_cnt,
      input  alu_y, alu_zero, rsp_ready,
      output cmd_ready, alu_sel, alu_a, alu_b,
      output rsp_valid, rsp_data, rsp_zero, rsp_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_cnt,
      output alu_y, alu_zero, rsp_ready,
      input  cmd_ready, alu_sel, alu_a, alu_b,
      input  rsp_valid, rsp_data, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time and sequences a combinational
// ALU through SINGLE, shift-add MUL and REPEAT operations, then holds the
// result on the response channel until it is taken.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_sequencer_if.slave (cmd_*, rsp_*, alu_*)
module alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, SINGLE, MUL_ADD, MUL_SHIFT, REP, DONE} state_t;

   localparam logic [7:0] LAST = 8'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0] mcand, mcand_nx;   // MUL multiplicand; b operand otherwise
   logic [WIDTH-1:0] mplier, mplier_nx;
   logic [7:0]       cnt, cnt_nx;
   logic [3:0]       op_sel, op_sel_nx;
   logic             zflag, zflag_nx;
   logic             err, err_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         op_sel <= '0;
         zflag  <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         mcand  <= mcand_nx;
         mplier <= mplier_nx;
         cnt    <= cnt_nx;
         op_sel <= op_sel_nx;
         zflag  <= zflag_nx;
         err    <= err_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      acc_nx        = acc;
      mcand_nx      = mcand;
      mplier_nx     = mplier;
      cnt_nx        = cnt;
      op_sel_nx     = op_sel;
      zflag_nx      = zflag;
      err_nx        = err;
      bus.cmd_ready = 1'b0;
      bus.alu_sel   = 4'b1111;
      bus.alu_a     = '0;
      bus.alu_b     = '0;

      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               op_sel_nx = bus.cmd_sel;
               mcand_nx  = bus.cmd_b;
               case (bus.cmd_op)
                  2'b00: begin
                     acc_nx   = bus.cmd_a;
                     state_nx = SINGLE;
                  end
                  2'b01: begin
                     acc_nx    = '0;
                     mcand_nx  = bus.cmd_a;
                     mplier_nx = bus.cmd_b;
                     cnt_nx    = '0;
                     state_nx  = MUL_ADD;
                  end
                  2'b10: begin
                     acc_nx   = bus.cmd_a;
                     cnt_nx   = bus.cmd_cnt;
                     state_nx = REP;
                  end
                  default: begin
                     // Reserved opcode: run one SINGLE cycle with the ALU
                     // forced to 1111 and flag the error.
                     acc_nx    = '0;
                     zflag_nx  = 1'b1;
                     err_nx    = 1'b1;
                     op_sel_nx = 4'b1111;
                     state_nx  = SINGLE;
                  end
               endcase
            end
         end

         SINGLE: begin
            bus.alu_sel = op_sel;
            bus.alu_a   = acc;
            bus.alu_b   = mcand;
            acc_nx      = bus.alu_y;
            zflag_nx    = bus.alu_zero;
            state_nx    = DONE;
         end

         MUL_ADD: begin
            // Add the shifted multiplicand when the current multiplier bit
            // is set, otherwise pass the accumulator through unchanged.
            bus.alu_sel = mplier[0] ? 4'b0100 : 4'b0000;
            bus.alu_a   = acc;
            bus.alu_b   = mcand;
            acc_nx      = bus.alu_y;
            zflag_nx    = bus.alu_zero;
            state_nx    = MUL_SHIFT;
         end

         MUL_SHIFT: begin
            bus.alu_sel = 4'b1101;
            bus.alu_a   = mcand;
            mcand_nx    = bus.alu_y;
            mplier_nx   = mplier >> 1;
            if (cnt == LAST) begin
               state_nx = DONE;
            end else begin
               cnt_nx   = cnt + 8'd1;
               state_nx = MUL_ADD;
            end
         end

         REP: begin
            bus.alu_a = acc;
            acc_nx    = bus.alu_y;
            zflag_nx  = bus.alu_zero;
            if (cnt == 8'd0) begin
               // Zero count still costs one pass-through cycle.
               bus.alu_sel = 4'b0000;
               state_nx    = DONE;
            end else begin
               bus.alu_sel = op_sel;
               bus.alu_b   = mcand;
               cnt_nx      = cnt - 8'd1;
               if (cnt == 8'd1) state_nx = DONE;
            end
         end

         DONE: begin
            if (bus.rsp_ready) begin
               err_nx   = 1'b0;
               state_nx = IDLE;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // acc/zflag/err only move outside DONE, so the response is stable while held.
   assign bus.rsp_valid = (state == DONE);
   assign bus.rsp_data  = acc;
   assign bus.rsp_zero  = zflag;
   assign bus.rsp_err   = err;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference ALU: 0000 pass a, 0010 a+1, 0100 a+b, 0110 a-b,
   // 1101 a<<1, 1111 zero, anything else a&b.
   always_comb begin
      case (bus.alu_sel)
         4'b0000: bus.alu_y = bus.alu_a;
         4'b0010: bus.alu_y = bus.alu_a + 32'd1;
         4'b0100: bus.alu_y = bus.alu_a + bus.alu_b;
         4'b0110: bus.alu_y = bus.alu_a - bus.alu_b;
         4'b1101: bus.alu_y = bus.alu_a << 1;
         4'b1111: bus.alu_y = '0;
         default: bus.alu_y = bus.alu_a & bus.alu_b;
      endcase
      bus.alu_zero = (bus.alu_y == '0);
   end

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [3:0] sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0] cnt;
      logic [31:0] exp_data;
      logic       exp_zero;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] cnt);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_sel   = sel;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_cnt   = cnt;
      chk("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = 32'hDEAD_BEEF;   // operands must already be latched
      bus.cmd_b     = 32'hDEAD_BEEF;
      bus.cmd_op    = 2'b11;
      bus.cmd_cnt   = 8'hFF;
   endtask

   // Counts negedges after the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) break;
      end
      if (!bus.rsp_valid) chk("rsp_valid_timeout", 64'(bus.rsp_valid), 64'd1);
   endtask

   initial begin
      int lat;

      vecs[0]  = '{"single_add",    2'b00, 4'b0100, 32'd5,        32'd7,        8'd0,  32'd12,       1'b0, 1'b0, 2};
      vecs[1]  = '{"single_sub0",   2'b00, 4'b0110, 32'd9,        32'd9,        8'd0,  32'd0,        1'b1, 1'b0, 2};
      vecs[2]  = '{"mul",           2'b01, 4'b0000, 32'd12345,    32'd6789,     8'd0,  32'd83810205, 1'b0, 1'b0, 65};
      vecs[3]  = '{"mul_trunc",     2'b01, 4'b0110, 32'h0001_0000, 32'h0001_0000, 8'd0, 32'd0,       1'b1, 1'b0, 65};
      vecs[4]  = '{"rep_inc10",     2'b10, 4'b0010, 32'd0,        32'd0,        8'd10, 32'd10,       1'b0, 1'b0, 11};
      vecs[5]  = '{"rep_shl31",     2'b10, 4'b1101, 32'd1,        32'd0,        8'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
      vecs[6]  = '{"rep_cnt0",      2'b10, 4'b0100, 32'd0,        32'd5,        8'd0,  32'd0,        1'b1, 1'b0, 2};
      vecs[7]  = '{"reserved",      2'b11, 4'b0100, 32'd5,        32'd7,        8'd0,  32'd0,        1'b1, 1'b1, 2};
      vecs[8]  = '{"after_reserved",2'b00, 4'b0100, 32'd1,        32'd2,        8'd0,  32'd3,        1'b0, 1'b0, 2};
      vecs[9]  = '{"mul_allones",   2'b01, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 32'd1,       1'b0, 1'b0, 65};
      vecs[10] = '{"rep_sub3",      2'b10, 4'b0110, 32'd100,      32'd7,        8'd3,  32'd79,       1'b0, 1'b0, 4};
      vecs[11] = '{"rep_cnt1",      2'b10, 4'b0100, 32'd10,       32'd5,        8'd1,  32'd15,       1'b0, 1'b0, 2};

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_sel   = 4'b0000;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_cnt   = '0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      chk("rst_rsp_zero",  64'(bus.rsp_zero),  64'd0);
      chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
      chk("rst_alu_sel",   64'(bus.alu_sel),   64'hF);
      chk("rst_alu_a",     64'(bus.alu_a),     64'd0);
      chk("rst_alu_b",     64'(bus.alu_b),     64'd0);
      rst_n = 1'b1;

      // Table-driven vectors; rsp_ready held high ahead of the response.
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cnt);
         wait_rsp(lat);
         chk({vecs[i].name, "_lat"},  64'(lat),           64'(vecs[i].exp_lat));
         chk({vecs[i].name, "_data"}, 64'(bus.rsp_data),  64'(vecs[i].exp_data));
         chk({vecs[i].name, "_zero"}, 64'(bus.rsp_zero),  64'(vecs[i].exp_zero));
         chk({vecs[i].name, "_err"},  64'(bus.rsp_err),   64'(vecs[i].exp_err));
         chk({vecs[i].name, "_busy"}, 64'(bus.cmd_ready), 64'd0);
         @(negedge clk);
         chk({vecs[i].name, "_idle_ready"}, 64'(bus.cmd_ready), 64'd1);
         chk({vecs[i].name, "_idle_valid"}, 64'(bus.rsp_valid), 64'd0);
      end

      // Backpressure in DONE: response held, new command ignored.
      bus.rsp_ready = 1'b0;
      send(2'b00, 4'b0100, 32'd20, 32'd22, 8'd0);
      wait_rsp(lat);
      chk("bp_lat", 64'(lat), 64'd2);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_sel   = 4'b0100;
      bus.cmd_a     = 32'd1;
      bus.cmd_b     = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",     64'(bus.rsp_valid), 64'd1);
         chk("bp_data",      64'(bus.rsp_data),  64'd42);
         chk("bp_zero",      64'(bus.rsp_zero),  64'd0);
         chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(bus.cmd_ready), 64'd1);
      chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);

      // Reset in the middle of a MUL.
      send(2'b01, 4'b0000, 32'd12345, 32'd6789, 8'd0);
      repeat (20) @(negedge clk);
      chk("midmul_busy", 64'(bus.cmd_ready), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midmul_rst_ready", 64'(bus.cmd_ready), 64'd1);
      chk("midmul_rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midmul_rst_sel",   64'(bus.alu_sel),   64'hF);
      chk("midmul_rst_data",  64'(bus.rsp_data),  64'd0);
      rst_n = 1'b1;
      send(2'b00, 4'b0100, 32'd3, 32'd4, 8'd0);
      wait_rsp(lat);
      chk("post_rst_lat",  64'(lat),          64'd2);
      chk("post_rst_data", 64'(bus.rsp_data), 64'd7);
      chk("post_rst_err",  64'(bus.rsp_err),  64'd0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
